mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetches and data loads/stores.
// Fetch completes 5 edges after accept, load len+1, store len; rdy_in low freezes all state.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_in,
    input  logic [17:0] if_addr_in,
    input  logic        if_flush_in,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    input  logic [2:0]  mem_len_in,
    input  logic [17:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [7:0]  ram_din_in,
    output logic        if_valid_out,
    output logic [31:0] if_inst_out,
    output logic        busy_if_out,
    output logic        mem_valid_out,
    output logic [31:0] mem_rdata_out,
    output logic        busy_mem_out,
    output logic [17:0] ram_a_out,
    output logic        ram_wr_out,
    output logic [7:0]  ram_dout_out
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t      r_state, w_state;
    logic [2:0]  r_cnt, w_cnt;
    logic [2:0]  r_len, w_len;
    logic [31:0] r_wdata, w_wdata;
    logic [31:0] r_buf, w_buf;
    logic        r_if_valid, w_if_valid;
    logic [31:0] r_if_inst, w_if_inst;
    logic        r_busy_if, w_busy_if;
    logic        r_mem_valid, w_mem_valid;
    logic [31:0] r_mem_rdata, w_mem_rdata;
    logic        r_busy_mem, w_busy_mem;
    logic [17:0] r_ram_a, w_ram_a;
    logic        r_ram_wr, w_ram_wr;
    logic [7:0]  r_ram_dout, w_ram_dout;

    logic [2:0]  w_cnt_inc;
    logic [1:0]  w_idx;

    // Lengths other than 1 or 2 are serviced as a full word.
    function automatic logic [2:0] f_len(input logic [2:0] len);
        case (len)
            3'd1:    f_len = 3'd1;
            3'd2:    f_len = 3'd2;
            default: f_len = 3'd4;
        endcase
    endfunction

    assign w_cnt_inc = r_cnt + 3'd1;
    // Byte arriving now was addressed two edges earlier.
    assign w_idx     = 2'(r_cnt - 3'd1);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_len       = r_len;
        w_wdata     = r_wdata;
        w_buf       = r_buf;
        w_if_valid  = 1'b0;
        w_if_inst   = r_if_inst;
        w_mem_valid = 1'b0;
        w_mem_rdata = r_mem_rdata;
        w_ram_a     = r_ram_a;
        w_ram_wr    = 1'b0;
        w_ram_dout  = r_ram_dout;

        case (r_state)
            IDLE: begin
                if (!if_flush_in) begin
                    if (mem_req_in) begin
                        w_state = mem_we_in ? MEM_WR : MEM_RD;
                        w_cnt   = 3'd0;
                        w_len   = f_len(mem_len_in);
                        w_ram_a = mem_addr_in;
                        w_buf   = 32'h0;
                        if (mem_we_in) begin
                            w_ram_wr   = 1'b1;
                            w_ram_dout = mem_wdata_in[7:0];
                            w_wdata    = {8'h00, mem_wdata_in[31:8]};
                        end
                    end else if (if_req_in) begin
                        w_state = IF_RD;
                        w_cnt   = 3'd0;
                        w_len   = 3'd4;
                        w_ram_a = if_addr_in;
                        w_buf   = 32'h0;
                    end
                end
            end

            IF_RD, MEM_RD: begin
                if (r_state == IF_RD && if_flush_in) begin
                    w_state = IDLE;
                    w_cnt   = 3'd0;
                end else begin
                    w_cnt = w_cnt_inc;
                    if (w_cnt_inc < r_len) begin
                        w_ram_a = r_ram_a + 18'd1;
                    end
                    if (r_cnt != 3'd0) begin
                        w_buf[{w_idx, 3'b000} +: 8] = ram_din_in;
                    end
                    if (r_cnt == r_len) begin
                        w_state = IDLE;
                        w_cnt   = 3'd0;
                        if (r_state == IF_RD) begin
                            w_if_inst  = w_buf;
                            w_if_valid = 1'b1;
                        end else begin
                            w_mem_rdata = w_buf;
                            w_mem_valid = 1'b1;
                        end
                    end
                end
            end

            MEM_WR: begin
                if (w_cnt_inc < r_len) begin
                    w_cnt      = w_cnt_inc;
                    w_ram_a    = r_ram_a + 18'd1;
                    w_ram_wr   = 1'b1;
                    w_ram_dout = r_wdata[7:0];
                    w_wdata    = {8'h00, r_wdata[31:8]};
                end else begin
                    w_state     = IDLE;
                    w_cnt       = 3'd0;
                    w_mem_valid = 1'b1;
                end
            end

            default: begin
                w_state = IDLE;
                w_cnt   = 3'd0;
            end
        endcase

        w_busy_if  = (w_state == IF_RD);
        w_busy_mem = (w_state == MEM_RD) || (w_state == MEM_WR);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_wdata     <= 32'h0;
            r_buf       <= 32'h0;
            r_if_valid  <= 1'b0;
            r_if_inst   <= 32'h0;
            r_busy_if   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_rdata <= 32'h0;
            r_busy_mem  <= 1'b0;
            r_ram_a     <= 18'h0;
            r_ram_wr    <= 1'b0;
            r_ram_dout  <= 8'h0;
        end else if (rdy_in) begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_len       <= w_len;
            r_wdata     <= w_wdata;
            r_buf       <= w_buf;
            r_if_valid  <= w_if_valid;
            r_if_inst   <= w_if_inst;
            r_busy_if   <= w_busy_if;
            r_mem_valid <= w_mem_valid;
            r_mem_rdata <= w_mem_rdata;
            r_busy_mem  <= w_busy_mem;
            r_ram_a     <= w_ram_a;
            r_ram_wr    <= w_ram_wr;
            r_ram_dout  <= w_ram_dout;
        end
    end

    assign if_valid_out  = r_if_valid;
    assign if_inst_out   = r_if_inst;
    assign busy_if_out   = r_busy_if;
    assign mem_valid_out = r_mem_valid;
    assign mem_rdata_out = r_mem_rdata;
    assign busy_mem_out  = r_busy_mem;
    assign ram_a_out     = r_ram_a;
    assign ram_wr_out    = r_ram_wr;
    assign ram_dout_out  = r_ram_dout;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM, transaction-level reference model, directed and random traffic.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, if_req_in, if_flush_in, mem_req_in, mem_we_in;
    logic [17:0] if_addr_in, mem_addr_in;
    logic [2:0]  mem_len_in;
    logic [31:0] mem_wdata_in;
    logic [7:0]  ram_din_in;
    logic        if_valid_out, busy_if_out, mem_valid_out, busy_mem_out, ram_wr_out;
    logic [31:0] if_inst_out, mem_rdata_out;
    logic [17:0] ram_a_out;
    logic [7:0]  ram_dout_out;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_flush_in(if_flush_in),
        .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_len_in(mem_len_in),
        .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .ram_din_in(ram_din_in),
        .if_valid_out(if_valid_out), .if_inst_out(if_inst_out), .busy_if_out(busy_if_out),
        .mem_valid_out(mem_valid_out), .mem_rdata_out(mem_rdata_out), .busy_mem_out(busy_mem_out),
        .ram_a_out(ram_a_out), .ram_wr_out(ram_wr_out), .ram_dout_out(ram_dout_out)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Synchronous RAM, one-edge read latency; frozen along with the controller.
    logic [7:0] ram [0:262143];
    always @(posedge clk) begin
        if (rdy_in) begin
            if (ram_wr_out) ram[ram_a_out] <= ram_dout_out;
            ram_din_in <= ram[ram_a_out];
        end
    end

    // Reference model: one transfer, tracked by edges elapsed since accept.
    int          m_kind;   // 0 none, 1 fetch, 2 load, 3 store
    int          m_len, m_j;
    logic [17:0] m_base;
    logic [31:0] m_wdata, m_data;
    logic        e_if_valid, e_busy_if, e_mem_valid, e_busy_mem, e_ram_wr;
    logic [31:0] e_if_inst, e_rdata;
    logic [17:0] e_ram_a;
    logic [7:0]  e_dout;

    function automatic int dec_len(input logic [2:0] l);
        if (l == 3'd1) return 1;
        if (l == 3'd2) return 2;
        return 4;
    endfunction

    always @(posedge clk) begin
        if (rst_in) begin
            m_kind = 0; m_j = 0;
            e_if_valid = 0; e_busy_if = 0; e_mem_valid = 0; e_busy_mem = 0; e_ram_wr = 0;
            e_if_inst = 0; e_rdata = 0; e_ram_a = 0; e_dout = 0;
        end else if (rdy_in) begin
            e_if_valid  = 0;
            e_mem_valid = 0;
            if (m_kind == 0) begin
                if (!if_flush_in && (mem_req_in || if_req_in)) begin
                    if (mem_req_in) begin
                        m_kind  = mem_we_in ? 3 : 2;
                        m_base  = mem_addr_in;
                        m_len   = dec_len(mem_len_in);
                        m_wdata = mem_wdata_in;
                    end else begin
                        m_kind = 1;
                        m_base = if_addr_in;
                        m_len  = 4;
                    end
                    m_j    = 0;
                    m_data = 0;
                    for (int k = 0; k < m_len; k++)
                        m_data[8*k +: 8] = ram[18'(m_base + 18'(k))];
                    e_ram_a = m_base;
                    if (m_kind == 3) begin
                        e_ram_wr = 1;
                        e_dout   = m_wdata[7:0];
                    end
                end
            end else begin
                m_j = m_j + 1;
                if (m_kind == 1 && if_flush_in) begin
                    m_kind = 0;
                end else if (m_kind == 3) begin
                    if (m_j < m_len) begin
                        e_ram_a  = 18'(m_base + 18'(m_j));
                        e_ram_wr = 1;
                        e_dout   = m_wdata[8*m_j +: 8];
                    end else begin
                        e_ram_wr    = 0;
                        e_mem_valid = 1;
                        m_kind      = 0;
                    end
                end else begin
                    if (m_j < m_len) e_ram_a = 18'(m_base + 18'(m_j));
                    if (m_j == m_len + 1) begin
                        if (m_kind == 1) begin
                            e_if_valid = 1; e_if_inst = m_data;
                        end else begin
                            e_mem_valid = 1; e_rdata = m_data;
                        end
                        m_kind = 0;
                    end
                end
            end
            e_busy_if  = (m_kind == 1);
            e_busy_mem = (m_kind >= 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("if_valid",  32'(if_valid_out),  32'(e_if_valid));
            chk("if_inst",   if_inst_out,        e_if_inst);
            chk("busy_if",   32'(busy_if_out),   32'(e_busy_if));
            chk("mem_valid", 32'(mem_valid_out), 32'(e_mem_valid));
            chk("mem_rdata", mem_rdata_out,      e_rdata);
            chk("busy_mem",  32'(busy_mem_out),  32'(e_busy_mem));
            chk("ram_a",     32'(ram_a_out),     32'(e_ram_a));
            chk("ram_wr",    32'(ram_wr_out),    32'(e_ram_wr));
            chk("ram_dout",  32'(ram_dout_out),  32'(e_dout));
        end
    end

    task automatic quiet();
        if_req_in = 0; if_flush_in = 0; mem_req_in = 0; mem_we_in = 0;
        if_addr_in = 0; mem_addr_in = 0; mem_len_in = 0; mem_wdata_in = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_valid"},  32'(if_valid_out),  0);
        chk({tag, "_if_inst"},   if_inst_out,        0);
        chk({tag, "_busy_if"},   32'(busy_if_out),   0);
        chk({tag, "_mem_valid"}, 32'(mem_valid_out), 0);
        chk({tag, "_mem_rdata"}, mem_rdata_out,      0);
        chk({tag, "_busy_mem"},  32'(busy_mem_out),  0);
        chk({tag, "_ram_a"},     32'(ram_a_out),     0);
        chk({tag, "_ram_wr"},    32'(ram_wr_out),    0);
        chk({tag, "_ram_dout"},  32'(ram_dout_out),  0);
    endtask

    // Returns the number of negedges until the chosen valid pulse; 0 on timeout.
    task automatic wait_valid(input bit is_if, output int n, output int busy_cnt, output int other_v);
        n = 0; busy_cnt = 0; other_v = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (is_if ? busy_if_out : busy_mem_out) busy_cnt++;
            if (is_if ? mem_valid_out : if_valid_out) other_v++;
            if (is_if ? if_valid_out : mem_valid_out) begin
                n = i;
                break;
            end
        end
    endtask

    logic [17:0] st_a [4];
    logic [7:0]  st_d [4];
    logic [17:0] exp_a [4];
    logic [7:0]  exp_d [4];

    initial begin
        int n, bc, ov, wc, sv;
        for (int i = 0; i < 262144; i++) ram[i] <= 8'($urandom);
        ram[18'h00010] <= 8'h13; ram[18'h00011] <= 8'h05;
        ram[18'h00012] <= 8'h10; ram[18'h00013] <= 8'h00;
        ram[18'h00100] <= 8'hAA; ram[18'h00101] <= 8'hBB;
        ram[18'h00200] <= 8'hDE; ram[18'h00201] <= 8'hAD;
        ram[18'h00202] <= 8'hBE; ram[18'h00203] <= 8'hEF;
        exp_a[0] = 18'h3FFFE; exp_a[1] = 18'h3FFFF; exp_a[2] = 18'h00000; exp_a[3] = 18'h00001;
        exp_d[0] = 8'h44; exp_d[1] = 8'h33; exp_d[2] = 8'h22; exp_d[3] = 8'h11;

        quiet();
        rst_in = 1; rdy_in = 1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_in = 0;
        chk_en = 1;

        // Fetch of a known word
        if_req_in = 1; if_addr_in = 18'h00010;
        wait_valid(1, n, bc, ov);
        if_req_in = 0;
        chk("fetch_latency", 32'(n - 1), 5);
        chk("fetch_inst", if_inst_out, 32'h00100513);
        chk("fetch_busy_cycles", 32'(bc), 5);

        // Load and fetch raised together: load wins
        @(negedge clk);
        if_req_in = 1; if_addr_in = 18'h00010;
        mem_req_in = 1; mem_we_in = 0; mem_len_in = 3'd2; mem_addr_in = 18'h00100;
        wait_valid(0, n, bc, ov);
        mem_req_in = 0;
        chk("cont_load_latency", 32'(n - 1), 3);
        chk("cont_load_data", mem_rdata_out, 32'h0000BBAA);
        chk("cont_no_early_fetch", 32'(ov), 0);
        @(negedge clk);
        chk("cont_fetch_accepted", 32'(busy_if_out), 1);
        wait_valid(1, n, bc, ov);
        if_req_in = 0;
        chk("cont_fetch_remaining", 32'(n), 5);
        chk("cont_fetch_inst", if_inst_out, 32'h00100513);

        // Word store across the address wrap
        @(negedge clk);
        mem_req_in = 1; mem_we_in = 1; mem_len_in = 3'd4;
        mem_addr_in = 18'h3FFFE; mem_wdata_in = 32'h11223344;
        wc = 0; n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ram_wr_out) begin
                if (wc < 4) begin st_a[wc] = ram_a_out; st_d[wc] = ram_dout_out; end
                wc++;
            end
            if (mem_valid_out) begin n = i; break; end
        end
        mem_req_in = 0; mem_we_in = 0;
        chk("store_wr_cycles", 32'(wc), 4);
        chk("store_latency", 32'(n - 1), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("store_addr%0d", i), 32'(st_a[i]), 32'(exp_a[i]));
            chk($sformatf("store_byte%0d", i), 32'(st_d[i]), 32'(exp_d[i]));
        end
        @(negedge clk);
        chk("store_ram_top", 32'(ram[18'h3FFFF]), 32'h33);
        chk("store_ram_low", 32'(ram[18'h00001]), 32'h11);

        // Flush at E2 of a fetch
        if_req_in = 1; if_addr_in = 18'h00010;
        sv = 0;
        @(negedge clk); if (if_valid_out) sv++;
        @(negedge clk); if (if_valid_out) sv++;
        if_flush_in = 1;
        @(negedge clk); if (if_valid_out) sv++;
        if_flush_in = 0; if_req_in = 0;
        chk("flush_busy_low", 32'(busy_if_out), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_valid_out) sv++;
        end
        chk("flush_no_valid", 32'(sv), 0);

        // Word load with a three-cycle freeze
        mem_req_in = 1; mem_we_in = 0; mem_len_in = 3'd4; mem_addr_in = 18'h00200;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mem_valid_out) begin n = i; break; end
            if (i == 2) rdy_in = 0;
            if (i == 5) rdy_in = 1;
        end
        rdy_in = 1; mem_req_in = 0;
        chk("stall_latency", 32'(n - 1), 8);
        chk("stall_data", mem_rdata_out, 32'hEFBEADDE);

        // Reset in the middle of a store
        @(negedge clk);
        mem_req_in = 1; mem_we_in = 1; mem_len_in = 3'd4;
        mem_addr_in = 18'h00050; mem_wdata_in = $urandom;
        @(negedge clk);
        chk("rststore_writing", 32'(ram_wr_out), 1);
        @(negedge clk);
        rst_in = 1; quiet();
        @(negedge clk);
        rst_in = 0;
        chk_all_zero("rststore");

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_in      = ($urandom_range(0, 299) == 0);
            rdy_in      = ($urandom_range(0, 7) != 0);
            if_req_in   = ($urandom_range(0, 2) != 0);
            if_flush_in = ($urandom_range(0, 24) == 0);
            mem_req_in  = ($urandom_range(0, 2) == 0);
            mem_we_in   = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 4))
                0:       mem_len_in = 3'd1;
                1:       mem_len_in = 3'd2;
                2:       mem_len_in = 3'd4;
                default: mem_len_in = 3'($urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                if_addr_in  = 18'(18'h3FFFC + 18'($urandom_range(0, 5)));
                mem_addr_in = 18'(18'h3FFFC + 18'($urandom_range(0, 5)));
            end else begin
                if_addr_in  = 18'($urandom);
                mem_addr_in = 18'($urandom);
            end
            mem_wdata_in = $urandom;
        end
        rst_in = 0; rdy_in = 1; quiet();
        repeat (10) @(negedge clk);
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
